// File: rtl/ram_burst_ctrl.sv
// ============================================================================
//  Module   : ram_burst_ctrl
//  Function : Burst sequencer for a single-port synchronous RAM. It turns
//             read/write burst commands into consecutive RAM accesses, with a
//             2-entry skid FIFO on the read path.
//  Option   : RAM_BURST_CSUM_EN adds a running checksum output (csum)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_ctrl #(
    parameter int DATA_WDTH = 32,
    parameter int ADDR_WDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [ADDR_WDTH-1:0] cmd_addr,
    input  logic [ADDR_WDTH:0]   cmd_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_WDTH-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_WDTH-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_we,
    output logic [ADDR_WDTH-1:0] ram_addr,
    output logic [DATA_WDTH-1:0] ram_din,
    input  logic [DATA_WDTH-1:0] ram_dout
`ifdef RAM_BURST_CSUM_EN
    ,
    output logic [DATA_WDTH-1:0] csum
`endif
);

    localparam int                   c_len_w    = ADDR_WDTH + 1;
    localparam logic [ADDR_WDTH-1:0] c_addr_one = 1;
    localparam logic [c_len_w-1:0]   c_len_one  = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WDTH-1:0]   r_addr;
    logic [c_len_w-1:0]     r_rem_issue;
    logic [c_len_w-1:0]     r_rem_deliver;
    logic                   r_inflight;
    logic [DATA_WDTH-1:0]   r_fifo [2];
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [1:0]             r_count;

    logic                   w_accept;
    logic                   w_wr_hs;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_issue;
    logic [2:0]             w_occ;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_wr_hs  = wr_valid && (r_state == S_WRITE);
    assign w_pop    = (r_count != 2'd0) && rd_ready;
    assign w_push   = r_inflight;
    // Slots committed after this edge: buffered + the word still in the RAM.
    assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = (r_state == S_READ) && (r_rem_issue != '0) && (w_occ < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        ram_din     = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept) begin
                    if (cmd_len == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (cmd_dir) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                ram_din  = wr_data;
                if (w_wr_hs && (r_rem_issue == c_len_one)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_READ: begin
                if (w_pop && (r_rem_deliver == c_len_one)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gating with rst keeps an aborted write burst from landing one more word.
    assign ram_we   = w_wr_hs && !rst;
    assign ram_addr = r_addr;
    assign rd_valid = (r_count != 2'd0);
    assign rd_data  = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_rem_issue   <= '0;
            r_rem_deliver <= '0;
            r_inflight    <= 1'b0;
            r_fifo[0]     <= '0;
            r_fifo[1]     <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_accept) begin
                r_addr        <= cmd_addr;
                r_rem_issue   <= cmd_len;
                r_rem_deliver <= cmd_len;
            end else if (w_wr_hs || w_issue) begin
                r_addr      <= r_addr + c_addr_one;
                r_rem_issue <= r_rem_issue - c_len_one;
            end
            if (!w_accept && w_pop) begin
                r_rem_deliver <= r_rem_deliver - c_len_one;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= ram_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef RAM_BURST_CSUM_EN
    logic [DATA_WDTH-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (w_wr_hs) begin
            r_csum <= r_csum + wr_data;
        end else if (w_pop) begin
            r_csum <= r_csum + rd_data;
        end
    end

    assign csum = r_csum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
// Testbench for ram_burst_ctrl: directed bursts plus randomized traffic,
// checked every cycle against a transaction-level reference model.
`default_nettype none

module tb_ram_burst_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int P_IDLE  = 0;
    localparam int P_WRITE = 1;
    localparam int P_READ  = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef RAM_BURST_CSUM_EN
    logic [DW-1:0] csum;
    logic [DW-1:0] csum_at_done = '0;
`endif

    ram_burst_ctrl #(.DATA_WDTH(DW), .ADDR_WDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef RAM_BURST_CSUM_EN
        ,
        .csum      (csum)
`endif
    );

    always #5 clk = ~clk;

    // RAM: 2048x32, registered read address
    logic [DW-1:0] ram_mem [DEPTH];
    logic [AW-1:0] ram_addr_q = '0;
    assign ram_dout = ram_mem[ram_addr_q];

    initial begin
        forever begin
            @(posedge clk);
            if (ram_we) ram_mem[ram_addr] = ram_din;
            ram_addr_q <= ram_addr;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_phase = P_IDLE;
    int            m_addr = 0;
    int            m_rem = 0;
    logic [DW-1:0] m_csum = '0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            chk_en = 0;

    int            cyc = 0;
    int            hs_edge = 0;
    int            first_rdv = -1;
    int            done_cyc = 0;
    int            done_cnt = 0;
    int            n_hs = 0;
    int            pops = 0;
    int            we_cnt = 0;
    logic [DW-1:0] rd_log [$];
    int            pop_cyc [$];
    int            we_cyc [$];
    int            we_addr [$];

    int            wr_mode = 0;
    int            wv_pct = 70;
    int            rd_mode = 0;
    int            rd_ph = 0;
    logic [DW-1:0] wseq [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Stimulus drivers for the data streams
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_mode == 1) begin
                wr_valid = 1'b1;
                wr_data  = (n_hs < 8) ? wseq[n_hs] : 32'h0;
            end else begin
                wr_valid = ($urandom_range(0, 99) < wv_pct);
                wr_data  = $urandom;
            end
            case (rd_mode)
                0: rd_ready = 1'b1;
                1: begin
                    rd_ready = (rd_ph == 0);
                    rd_ph    = (rd_ph + 1) % 3;
                end
                default: rd_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Compare process: outputs of this cycle against the model, then advance
    initial begin
        int nxt;
        logic [DW-1:0] exp_word;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                nxt = m_phase;
                if (rst) begin
                    chk("ram_we_during_rst", ram_we, 0);
                    nxt = P_IDLE;
                end else begin
                    chk("busy", busy, m_phase != P_IDLE);
                    chk("cmd_ready", cmd_ready, m_phase == P_IDLE);
                    chk("done", done, m_phase == P_DONE);
                    chk("wr_ready", wr_ready, m_phase == P_WRITE);
                    if (m_phase != P_WRITE) chk("ram_we_idle", ram_we, 0);
                    case (m_phase)
                        P_IDLE: begin
                            chk("rd_valid_idle", rd_valid, 0);
                            if (cmd_valid) begin
                                m_addr    = cmd_addr;
                                m_rem     = cmd_len;
                                m_csum    = '0;
                                hs_edge   = cyc + 1;
                                first_rdv = -1;
                                if (cmd_len == 0) nxt = P_DONE;
                                else if (cmd_dir) nxt = P_WRITE;
                                else nxt = P_READ;
                            end
                        end
                        P_WRITE: begin
                            chk("ram_we_write", ram_we, wr_valid);
                            if (wr_valid) begin
                                chk("ram_addr", ram_addr, m_addr);
                                chk("ram_din", ram_din, wr_data);
                                ref_mem[m_addr] = wr_data;
                                m_csum = m_csum + wr_data;
                                we_cyc.push_back(cyc);
                                we_addr.push_back(m_addr);
                                we_cnt++;
                                n_hs++;
                                m_addr = (m_addr + 1) % DEPTH;
                                m_rem--;
                                if (m_rem == 0) nxt = P_DONE;
                            end
                        end
                        P_READ: begin
                            if (rd_valid && first_rdv < 0) first_rdv = cyc;
                            if (rd_valid && rd_ready) begin
                                exp_word = ref_mem[m_addr];
                                chk("rd_data", rd_data, exp_word);
                                rd_log.push_back(rd_data);
                                pop_cyc.push_back(cyc);
                                m_csum = m_csum + exp_word;
                                pops++;
                                m_addr = (m_addr + 1) % DEPTH;
                                m_rem--;
                                if (m_rem == 0) nxt = P_DONE;
                            end
                        end
                        default: begin
                            done_cyc = cyc;
                            done_cnt++;
`ifdef RAM_BURST_CSUM_EN
                            csum_at_done = csum;
                            chk("csum_at_done", csum, m_csum);
`endif
                            nxt = P_IDLE;
                        end
                    endcase
                end
                m_phase = nxt;
            end
        end
    end

    task automatic send_cmd(input logic dir, input int addr, input int len);
        bit got;
        got = 0;
        cmd_dir   = dir;
        cmd_addr  = addr[AW-1:0];
        cmd_len   = len[AW:0];
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_timeout: got cmd_ready=0 expected 1 within 200 cycles");
        end
        cmd_valid = 1'b0;
        cmd_dir   = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_len   = (AW+1)'($urandom);
    endtask

    task automatic wait_idle(input int budget, output int busy_cycles);
        int i;
        busy_cycles = 0;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
        end
        if (i == budget) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        pop_cyc.delete();
        we_cyc.delete();
        we_addr.delete();
        n_hs = 0;
    endtask

    initial begin
        int bc;
        int dc0;
        int we0;
        int bound;
        logic [DW-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            ram_mem[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
`ifdef RAM_BURST_CSUM_EN
        chk("rst_csum", csum, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;

        // Write burst 0x010, len 4, data A0..A3 back-to-back
        wseq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0};
        clear_logs();
        wr_mode = 1;
        send_cmd(1'b1, 32'h010, 4);
        wait_idle(50, bc);
        wr_mode = 0;
        chk("wr_count", we_cyc.size(), 4);
        if (we_cyc.size() == 4) begin
            chk("wr_consecutive", we_cyc[3] - we_cyc[0], 3);
            chk("wr_done_latency", done_cyc - we_cyc[3], 1);
            for (int i = 0; i < 4; i++) chk("wr_addr_seq", we_addr[i], 32'h010 + i);
        end
        for (int i = 0; i < 4; i++) chk("wr_ram_content", ram_mem[32'h010 + i], 32'hA0 + i);

        // Read back with rd_ready held high
        clear_logs();
        rd_mode = 0;
        send_cmd(1'b0, 32'h010, 4);
        wait_idle(50, bc);
        chk("rd_first_latency", first_rdv - hs_edge, 2);
        chk("rd_count", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rd_word", rd_log[i], 32'hA0 + i);
            chk("rd_consecutive", pop_cyc[3] - pop_cyc[0], 3);
            chk("rd_done_latency", done_cyc - pop_cyc[3], 1);
        end

        // Same read under 1,0,0 backpressure
        clear_logs();
        rd_ph = 0;
        rd_mode = 1;
        send_cmd(1'b0, 32'h010, 4);
        wait_idle(80, bc);
        chk("bp_count", rd_log.size(), 4);
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("bp_word", rd_log[i], 32'hA0 + i);
        rd_mode = 0;

        // Wrap-around write and read at 0x7FE
        wseq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, 0, 0, 0};
        clear_logs();
        wr_mode = 1;
        send_cmd(1'b1, 32'h7FE, 4);
        wait_idle(50, bc);
        wr_mode = 0;
        chk("wrap_count", we_addr.size(), 4);
        if (we_addr.size() == 4) begin
            chk("wrap_addr0", we_addr[0], 32'h7FE);
            chk("wrap_addr1", we_addr[1], 32'h7FF);
            chk("wrap_addr2", we_addr[2], 32'h000);
            chk("wrap_addr3", we_addr[3], 32'h001);
        end
        chk("wrap_mem_7ff", ram_mem[11'h7FF], 32'hB1);
        chk("wrap_mem_000", ram_mem[0], 32'hB2);
        clear_logs();
        rd_mode = 2;
        send_cmd(1'b0, 32'h7FE, 4);
        wait_idle(80, bc);
        chk("wrap_rd_count", rd_log.size(), 4);
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("wrap_rd_word", rd_log[i], 32'hB0 + i);

        // Zero-length command
        we0 = we_cnt;
        dc0 = done_cnt;
        send_cmd(1'b1, 32'h123, 0);
        wait_idle(20, bc);
        chk("len0_busy_cycles", bc, 1);
        chk("len0_done_pulses", done_cnt - dc0, 1);
        chk("len0_no_ram_write", we_cnt - we0, 0);

        // Reset in the middle of an 8-word read after 3 words
        rd_mode = 0;
        dc0 = done_cnt;
        pops = 0;
        send_cmd(1'b0, 32'h040, 8);
        bound = 0;
        while (pops < 3 && bound < 50) begin
            @(negedge clk);
            #1;
            bound++;
        end
        chk("rst_mid_pops_reached", pops >= 3, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
`ifdef RAM_BURST_CSUM_EN
        chk("abort_csum", csum, 0);
`endif
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        @(posedge clk);
        #1;

        // Checksum wrap: 0xFFFFFFFF + 2
        wseq = '{32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0, 0, 0, 0};
        clear_logs();
        wr_mode = 1;
        send_cmd(1'b1, 32'h300, 2);
        wait_idle(20, bc);
        wr_mode = 0;
        chk("csum_mem_word", ram_mem[11'h301], 32'h2);
`ifdef RAM_BURST_CSUM_EN
        chk("csum_literal", csum_at_done, 32'h1);
`endif

        // Randomized bursts
        for (int n = 0; n < 60; n++) begin
            wv_pct  = $urandom_range(20, 100);
            rd_mode = $urandom_range(0, 2);
            rd_ph   = 0;
            bound   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
            send_cmd(1'($urandom), $urandom_range(0, DEPTH - 1), bound);
            wait_idle(bound * 12 + 40, bc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Full address space: write every word once, then read it back
        wv_pct = 60;
        send_cmd(1'b1, 32'h5A5, DEPTH);
        wait_idle(DEPTH * 20, bc);
        clear_logs();
        rd_mode = 2;
        send_cmd(1'b0, 32'h5A5, DEPTH);
        wait_idle(DEPTH * 20, bc);
        chk("full_rd_count", rd_log.size(), DEPTH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Burst sequencer placed directly upstream of the single-port synchronous RAM (2048x32, registered read address). It takes a command (read or write, base address, length) and turns it into consecutive RAM accesses. Write bursts take data from a valid/ready input stream; read bursts deliver data on a valid/ready output stream. A 2-entry skid FIFO absorbs the RAM's one-cycle read latency under backpressure.

Parameters:
DATA_WDTH, 32, RAM word width
ADDR_WDTH, 11, RAM address width; address space 2**ADDR_WDTH words

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command (IDLE only)
cmd_dir  in  1  0 = read burst, 1 = write burst
cmd_addr  in  ADDR_WDTH  burst base address
cmd_len  in  ADDR_WDTH+1  word count, 0..2**ADDR_WDTH
wr_valid  in  1  write data offered
wr_ready  out  1  write data accepted
wr_data  in  DATA_WDTH  write word
rd_valid  out  1  read word available
rd_ready  in  1  consumer accepts read word
rd_data  out  DATA_WDTH  read word
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at burst completion
ram_we  out  1  to RAM we
ram_addr  out  ADDR_WDTH  to RAM ADDR
ram_din  out  DATA_WDTH  to RAM Din
ram_dout  in  DATA_WDTH  from RAM Dout

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, FIFO and in-flight flag cleared. Outputs: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, ram_we=0, ram_addr=0, ram_din=0.
- Reset mid-burst: abort immediately with no further RAM writes. Remaining words are dropped, buffered read data is flushed, and done is not pulsed.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - On cmd_valid&cmd_ready, latch addr, len and dir.
  - len=0 goes to DONE.
  - Otherwise go to WRITE (dir=1) or READ (dir=0).
  - Command fields are ignored while cmd_ready=0.
- WRITE:
  - wr_ready=1.
  - ram_we = wr_valid (combinational), with ram_addr = current addr and ram_din = wr_data.
  - Each handshake writes the word at that edge, increments addr and decrements remaining.
  - The last handshake moves to DONE.
  - Throughput is one word per cycle.
- READ, issue side:
  - Issue condition: remaining_issue>0 and (fifo_count + inflight - pop) < 2, where pop = rd_valid&rd_ready.
  - On issue: drive ram_addr = addr, set inflight, increment addr, decrement remaining_issue.
- READ, capture side:
  - The cycle after an issue, ram_dout is valid and is pushed into the FIFO; inflight clears unless re-issued.
- READ, output side:
  - rd_valid = fifo_count!=0; rd_data = FIFO head.
  - Order is preserved.
  - Sustains one word per cycle when rd_ready is held high.
  - When both remaining_issue=0 and remaining_deliver=0 (pop of the last word), go to DONE.
- Read latency: with rd_ready=1, the first rd_valid appears 2 cycles after the command handshake (1 cycle to enter READ and issue, 1 cycle of RAM latency into the FIFO).
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in DONE.
- Address arithmetic: addr increments modulo 2**ADDR_WDTH (0x7FF wraps to 0x000). cmd_len=2**ADDR_WDTH touches every word once.
- ram_we=0 in every state except WRITE with wr_valid=1. The RAM is never written during READ.
- Keep the FIFO push (capture) and pop (output) in the same cycle legal; fifo_count is unchanged in that case.

Optional Feature:
Macro RAM_BURST_CSUM_EN.
- Defined:
  - Extra output csum (DATA_WDTH).
  - Cleared on command accept.
  - Adds each transferred word modulo 2**DATA_WDTH: wr_data on each write handshake, rd_data on each rd handshake.
  - Stable and valid from the done pulse until the next command accept; 0 after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Write burst: cmd dir=1, addr=0x010, len=4, wr_data 0xA0..0xA3 with wr_valid constant -> ram_we high 4 consecutive cycles at 0x010..0x013; done one cycle after the last write.
- Read back: cmd dir=0, addr=0x010, len=4, rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; first rd_valid 2 cycles after the handshake; then done.
- Backpressure: same read with rd_ready toggling 1,0,0,1,... -> no loss or duplication, order preserved, never more than 2 words buffered.
- Wrap-around: write then read addr=0x7FE, len=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001; data matches.
- len=0 and reset: len=0 -> busy for 1 cycle, done pulse, no RAM access. rst asserted during a read of len=8 after 3 words -> next cycle IDLE, rd_valid=0, no done pulse.
- With RAM_BURST_CSUM_EN: write 0xFFFFFFFF, 0x00000002 -> csum=0x00000001 at done.
